// File: rtl/mii64_tx_framer_if.sv
// mii64 TX framer stream bundle.
// Upstream words in (In*, InRdy), framed mii64 words out (Tx*).
interface mii64_tx_framer_if;
  logic        InDv;
  logic [63:0] InD;
  logic        InSof;
  logic        InEof;
  logic [2:0]  InMod;
  logic        InRdy;
  logic        Txdv;
  logic [63:0] Txd;
  logic        TxSof;
  logic        TxEof;
  logic [2:0]  TxMod;

  modport master (
    output InDv, InD, InSof, InEof, InMod,
    input  InRdy,
    input  Txdv, Txd, TxSof, TxEof, TxMod
  );

  modport slave (
    input  InDv, InD, InSof, InEof, InMod,
    output InRdy,
    output Txdv, Txd, TxSof, TxEof, TxMod
  );
endinterface

// File: rtl/mii64_tx_framer.sv
// mii64 TX framer: prepends preamble, passes data words through,
// aborts on underrun/oversize and enforces the inter-frame gap.
module mii64_tx_framer #(
  parameter int IFG_CYC   = 2,
  parameter int MAX_WORDS = 1200
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             TxEn,
  mii64_tx_framer_if.slave mii,
  output logic [31:0]      PktCnt,
  output logic [15:0]      UnderrunCnt
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  localparam logic [1:0] IFG  = 2'd3;

  localparam logic [63:0] PREAMBLE =
    64'h5555_5555_5555_55D5;
  localparam logic [10:0] LAST_WORD =
    11'(MAX_WORDS - 1);
  localparam logic [3:0]  IFG_LAST =
    4'(IFG_CYC - 1);

  logic [1:0]  rst_sync;
  logic        rst_n;

  logic [1:0]  state, state_nx;
  logic [10:0] wcnt, wcnt_nx;
  logic [3:0]  ifg_cnt, ifg_nx;

  logic        dv_q, sof_q, eof_q;
  logic [2:0]  mod_q;
  logic [63:0] d_q;

  logic        dv_nx, sof_nx, eof_nx;
  logic [2:0]  mod_nx;
  logic [63:0] d_nx;

  logic        rdy, pkt_inc, abort;

  // Assert immediately, release two edges later.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    ifg_nx   = ifg_cnt;
    dv_nx    = 1'b0;
    sof_nx   = 1'b0;
    eof_nx   = 1'b0;
    mod_nx   = 3'd0;
    d_nx     = '0;
    rdy      = 1'b0;
    pkt_inc  = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = mii.InDv & ~mii.InSof;
        if (mii.InDv & mii.InSof & TxEn) begin
          dv_nx    = 1'b1;
          sof_nx   = 1'b1;
          d_nx     = PREAMBLE;
          wcnt_nx  = '0;
          state_nx = DATA;
        end
      end
      DATA: begin
        rdy = 1'b1;
        if (!mii.InDv) begin
          abort = 1'b1;
        end else begin
          wcnt_nx = wcnt + 11'd1;
          if (mii.InEof) begin
            dv_nx    = 1'b1;
            d_nx     = mii.InD;
            eof_nx   = 1'b1;
            mod_nx   = mii.InMod;
            pkt_inc  = 1'b1;
            ifg_nx   = '0;
            state_nx = IFG;
          end else if (wcnt == LAST_WORD) begin
            abort = 1'b1;
          end else begin
            dv_nx = 1'b1;
            d_nx  = mii.InD;
          end
        end
      end
      DROP: begin
        rdy = 1'b1;
        if (mii.InDv & mii.InEof) begin
          ifg_nx   = '0;
          state_nx = IFG;
        end
      end
      IFG: begin
        ifg_nx = ifg_cnt + 4'd1;
        if (ifg_cnt == IFG_LAST) begin
          ifg_nx   = '0;
          state_nx = IDLE;
        end
      end
    endcase
    // Abort word: Txdv=1, TxEof=1, TxMod=1, Txd=0.
    if (abort) begin
      dv_nx    = 1'b1;
      eof_nx   = 1'b1;
      mod_nx   = 3'd1;
      d_nx     = '0;
      state_nx = DROP;
    end
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      ifg_cnt     <= '0;
      dv_q        <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      mod_q       <= 3'd0;
      d_q         <= '0;
      PktCnt      <= '0;
      UnderrunCnt <= '0;
    end else begin
      state   <= state_nx;
      wcnt    <= wcnt_nx;
      ifg_cnt <= ifg_nx;
      dv_q    <= dv_nx;
      sof_q   <= sof_nx;
      eof_q   <= eof_nx;
      mod_q   <= mod_nx;
      d_q     <= d_nx;
      if (pkt_inc)
        PktCnt <= PktCnt + 32'd1;
      if (abort && UnderrunCnt != 16'hFFFF)
        UnderrunCnt <= UnderrunCnt + 16'd1;
    end
  end

  assign mii.InRdy = rdy & rst_n;
  assign mii.Txdv  = dv_q;
  assign mii.Txd   = d_q;
  assign mii.TxSof = sof_q;
  assign mii.TxEof = eof_q;
  assign mii.TxMod = mod_q;
endmodule

// File: tb/tb_mii64_tx_framer.sv
// Bench for mii64_tx_framer: packet table + scoreboard,
// plus hand sequences for gap, stall and reset corners.
module tb_mii64_tx_framer;
  localparam int IFGC = 2;
  localparam int MAXW = 128;
  localparam logic [63:0] PRE = 64'h55555555555555D5;

  typedef struct packed {
    logic [63:0] d;
    logic        sof;
    logic        eof;
    logic [2:0]  mod;
  } exp_t;

  typedef struct {
    int         len;
    logic [2:0] mod;
    int         stall;
    bit         txen_off;
    int         exp_pkt;
    int         exp_und;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        TxEn;
  logic [31:0] PktCnt;
  logic [15:0] UnderrunCnt;

  mii64_tx_framer_if mi ();

  mii64_tx_framer #(
    .IFG_CYC   (IFGC),
    .MAX_WORDS (MAXW)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .TxEn        (TxEn),
    .mii         (mi),
    .PktCnt      (PktCnt),
    .UnderrunCnt (UnderrunCnt)
  );

  always #5 Clk = ~Clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   eof_cyc = 0;
  int   sof_gap = -1;
  int   first_wait = 0;
  exp_t sbq[$];
  vec_t vecs[7];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(posedge Clk) cyc++;

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge Clk) begin
    exp_t e;
    if (mi.Txdv) begin
      if (sbq.size() == 0) begin
        chk("tx_unexpected", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("txd", mi.Txd, e.d);
        chk("txsof", 64'(mi.TxSof), 64'(e.sof));
        chk("txeof", 64'(mi.TxEof), 64'(e.eof));
        chk("txmod", 64'(mi.TxMod), 64'(e.mod));
      end
      if (mi.TxEof) eof_cyc = cyc;
      if (mi.TxSof) sof_gap = cyc - eof_cyc;
    end else begin
      chk("tx_idle_zero",
          {mi.Txd | 64'(mi.TxMod) | 64'(mi.TxSof)
           | 64'(mi.TxEof)}, 64'd0);
    end
  end

  task automatic push(input logic [63:0] d, input logic sof,
                      input logic eof, input logic [2:0] m);
    exp_t e;
    e.d = d; e.sof = sof; e.eof = eof; e.mod = m;
    sbq.push_back(e);
  endtask

  task automatic idle_in();
    mi.InDv = 1'b0; mi.InD = '0; mi.InSof = 1'b0;
    mi.InEof = 1'b0; mi.InMod = 3'd0;
  endtask

  task automatic xfer(input logic [63:0] d, input logic sof,
                      input logic eof, input logic [2:0] m,
                      output int waits);
    mi.InDv = 1'b1; mi.InD = d; mi.InSof = sof;
    mi.InEof = eof; mi.InMod = m;
    waits = 0;
    forever begin
      @(negedge Clk);
      waits++;
      if (mi.InRdy) break;
      if (waits > 1000) begin
        chk("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic send_pkt(input int pid, input int n,
                          input logic [2:0] m, input int stall,
                          input bit txen_off);
    bit          dropping = 1'b0;
    logic        eof;
    logic [63:0] w;
    int          wt;
    push(PRE, 1'b1, 1'b0, 3'd0);
    for (int i = 1; i <= n; i++) begin
      eof = (i == n);
      w = {8'(pid), 8'(i), 16'hA5C3, 32'($urandom)};
      if (!dropping && i == stall) begin
        mi.InDv = 1'b0;
        @(posedge Clk);
        #1;
        push(64'd0, 1'b0, 1'b1, 3'd1);
        dropping = 1'b1;
      end
      if (!dropping) begin
        if (i == MAXW && !eof) begin
          push(64'd0, 1'b0, 1'b1, 3'd1);
          dropping = 1'b1;
        end else begin
          push(w, 1'b0, eof, eof ? m : 3'd0);
        end
      end
      xfer(w, i == 1, eof, m, wt);
      if (i == 1) first_wait = wt;
      if (i == 1 && txen_off) TxEn = 1'b0;
    end
  endtask

  initial begin
    int wt;
    vecs[0] = '{8,   3'd0, 0, 1'b0, 1, 0};
    vecs[1] = '{1,   3'd3, 0, 1'b0, 2, 0};
    vecs[2] = '{8,   3'd0, 4, 1'b0, 2, 1};
    vecs[3] = '{5,   3'd5, 0, 1'b1, 3, 1};
    vecs[4] = '{150, 3'd0, 0, 1'b0, 3, 2};
    vecs[5] = '{128, 3'd7, 0, 1'b0, 4, 2};
    vecs[6] = '{3,   3'd1, 2, 1'b0, 4, 3};

    Reset_n = 1'b1;
    TxEn = 1'b1;
    idle_in();
    #3 Reset_n = 1'b0;
    mi.InDv = 1'b1;
    #1;
    chk("rst_inrdy", 64'(mi.InRdy), 64'd0);
    chk("rst_txdv", 64'(mi.Txdv), 64'd0);
    chk("rst_pktcnt", 64'(PktCnt), 64'd0);
    chk("rst_undcnt", 64'(UnderrunCnt), 64'd0);
    repeat (3) @(posedge Clk);
    #1;
    idle_in();
    Reset_n = 1'b1;
    repeat (4) @(posedge Clk);
    #1;

    for (int v = 0; v < 7; v++) begin
      send_pkt(v, vecs[v].len, vecs[v].mod,
               vecs[v].stall, vecs[v].txen_off);
      idle_in();
      TxEn = 1'b1;
      repeat (8) @(posedge Clk);
      #1;
      chk($sformatf("v%0d_pktcnt", v),
          64'(PktCnt), 64'(vecs[v].exp_pkt));
      chk($sformatf("v%0d_undcnt", v),
          64'(UnderrunCnt), 64'(vecs[v].exp_und));
      chk($sformatf("v%0d_sb_empty", v),
          64'(sbq.size()), 64'd0);
    end

    // Stray word in IDLE, then SOF held off by TxEn=0.
    mi.InDv = 1'b1; mi.InSof = 1'b0;
    mi.InD = 64'hDEAD_BEEF_0000_0001;
    @(negedge Clk);
    chk("stray_inrdy", 64'(mi.InRdy), 64'd1);
    @(posedge Clk);
    #1;
    idle_in();
    TxEn = 1'b0;
    fork
      begin
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("stall_inrdy", 64'(mi.InRdy), 64'd0);
        chk("stall_txdv", 64'(mi.Txdv), 64'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1 TxEn = 1'b1;
      end
      send_pkt(20, 4, 3'd2, 0, 1'b0);
    join
    idle_in();
    chk("stall_sof_wait", 64'(first_wait), 64'd7);
    repeat (6) @(posedge Clk);
    #1;
    chk("stall_pktcnt", 64'(PktCnt), 64'd5);

    // Back-to-back packets with InDv held high.
    send_pkt(30, 3, 3'd4, 0, 1'b0);
    send_pkt(31, 2, 3'd6, 0, 1'b0);
    idle_in();
    chk("b2b_rdy_low", 64'(first_wait - 1), 64'(IFGC + 1));
    repeat (6) @(posedge Clk);
    #1;
    chk("b2b_sof_gap", 64'(sof_gap), 64'd3);
    chk("b2b_pktcnt", 64'(PktCnt), 64'd7);

    // Reset during word 5 of a packet.
    push(PRE, 1'b1, 1'b0, 3'd0);
    for (int i = 1; i <= 4; i++) begin
      logic [63:0] w;
      w = {8'd40, 8'(i), 48'h1234_5678_9ABC};
      push(w, 1'b0, 1'b0, 3'd0);
      xfer(w, i == 1, 1'b0, 3'd0, wt);
    end
    mi.InD = 64'hFFFF_0000_FFFF_0005;
    mi.InSof = 1'b0;
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    chk("mid_rst_txdv", 64'(mi.Txdv), 64'd0);
    chk("mid_rst_txd", mi.Txd, 64'd0);
    chk("mid_rst_inrdy", 64'(mi.InRdy), 64'd0);
    chk("mid_rst_pktcnt", 64'(PktCnt), 64'd0);
    chk("mid_rst_undcnt", 64'(UnderrunCnt), 64'd0);
    chk("mid_rst_sb", 64'(sbq.size()), 64'd0);
    repeat (2) @(posedge Clk);
    #1;
    idle_in();
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    send_pkt(50, 2, 3'd0, 0, 1'b0);
    idle_in();
    chk("post_rst_sof_wait", 64'(first_wait), 64'd2);
    repeat (6) @(posedge Clk);
    #1;
    chk("post_rst_pktcnt", 64'(PktCnt), 64'd1);
    chk("post_rst_sb", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/mii64_tx_framer.md
MII64_TX_FRAMER -- requirements
Module: mii64_tx_framer

Interface
REQ-001 SHALL have parameter IFG_CYC, default 2 (legal 1..15), the minimum number of Txdv=0 cycles after a TxEof word before the next TxSof.
REQ-002 SHALL have parameter MAX_WORDS, default 1200, the maximum number of data words per packet before a forced abort.
REQ-003 Port Clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port Reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port TxEn, input, 1: when 1, new packets may start; it is sampled only in IDLE.
REQ-006 Port InDv, input, 1: upstream word valid.
REQ-007 Port InD, input, 64: upstream data; InD[63:56] is the first byte on the wire.
REQ-008 Port InSof, input, 1: the word is the first word of a packet (destination MAC first).
REQ-009 Port InEof, input, 1: the word is the last word of a packet.
REQ-010 Port InMod, input, 3: number of valid bytes in the EOF word; 0 means 8.
REQ-011 Port InRdy, output, 1: a word is consumed when InDv&InRdy=1.
REQ-012 Port Txdv/Txd/TxSof/TxEof/TxMod, outputs, 1/64/1/1/3: the mii64 stream to the XGMII TX interface, using the same byte order and Mod encoding as the input.
REQ-013 Port PktCnt, output, 32: number of packets completed normally, wrapping.
REQ-014 Port UnderrunCnt, output, 16: number of aborted packets, saturating at 16'hFFFF.

Function
REQ-015 SHALL implement the states IDLE, DATA, DROP and IFG.
REQ-016 Txd/Txdv/TxSof/TxEof/TxMod SHALL all be registered; the output for an accepted word appears one cycle after acceptance.
REQ-017 InRdy SHALL be combinational from state and inputs:
- 1 in DATA and in DROP.
- 1 in IDLE when InDv&~InSof.
- 0 otherwise.
REQ-018 In IDLE, InDv&~InSof (a stray word) SHALL be consumed and discarded with no output.
REQ-019 In IDLE, InDv&InSof&TxEn SHALL cause the following, without consuming the word:
- Next cycle: Txdv=1, TxSof=1, TxEof=0, TxMod=0, Txd=64'h55555555555555D5 (preamble plus SFD).
- State goes to DATA.
REQ-020 In IDLE, a word with InDv&InSof while TxEn=0 SHALL wait with InRdy=0.
REQ-021 In DATA, each accepted word SHALL be output next cycle with Txdv=1, TxSof=0, Txd=InD; TxEof and TxMod SHALL follow InEof and InMod (TxMod=0 when not EOF).
REQ-022 InSof SHALL be ignored in DATA.
REQ-023 An accepted InEof in DATA SHALL increment PktCnt and move to IFG.
REQ-024 A 1-word packet (InSof&InEof) SHALL be legal: preamble word, then one EOF word.
REQ-025 In DATA with InDv=0 (underrun) the block SHALL do all of the following:
- Output, next cycle, the abort word: Txdv=1, TxEof=1, TxMod=1, Txd=0.
- Increment UnderrunCnt (saturating).
- Move to DROP; PktCnt is not incremented.
REQ-026 An oversize packet SHALL be aborted: when the MAX_WORDS-th data word is accepted without InEof, that word SHALL be replaced by the abort word, UnderrunCnt SHALL increment and the state SHALL move to DROP.
REQ-027 DROP SHALL consume and discard words with Txdv=0 until an accepted InEof, then move to IFG.
REQ-028 IFG SHALL hold Txdv=0 and InRdy=0 for exactly IFG_CYC cycles, then return to IDLE; the IDLE cycle that sees a SOF is additional to these.
REQ-029 The data word counter SHALL be 11 bits, SHALL clear on each preamble, and SHALL not wrap before MAX_WORDS.
REQ-030 When Txdv=0, the block SHALL drive Txd=0, TxSof=0, TxEof=0 and TxMod=0.
REQ-031 TxEn deasserting outside IDLE SHALL NOT affect a packet in progress.

Reset
REQ-032 Reset_n=0 SHALL immediately force state=IDLE, all Tx* outputs to 0, IFG count to 0, word count to 0, PktCnt=0 and UnderrunCnt=0.
REQ-033 While Reset_n=0, InRdy SHALL be 0.
REQ-034 Release of Reset_n SHALL be synchronised so that the first active edge is clean; there SHALL be no IFG wait after reset.
REQ-035 Reset mid-packet SHALL truncate the output with no EOF; the upstream is responsible for flushing.

Verification
REQ-036 64-byte packet (8 words, InMod=0, contiguous, TxEn=1) after reset -> preamble 64'h55555555555555D5 with TxSof=1, 8 passthrough words, last word TxEof=1 TxMod=0, then 2 idle cycles; PktCnt=1.
REQ-037 Two back-to-back packets with InDv held high -> InRdy=0 for IFG_CYC+1 cycles after the first EOF is accepted; the second preamble appears 3 cycles after the first TxEof (IFG_CYC=2).
REQ-038 InDv=0 at the 4th data word -> next cycle Txd=0, TxEof=1, TxMod=1; UnderrunCnt=1; the rest of the packet is drained with Txdv=0; PktCnt unchanged.
REQ-039 150-word packet with MAX_WORDS=128 -> word 128 replaced by the abort word; 22 words dropped; UnderrunCnt=1.
REQ-040 Stray non-SOF word in IDLE -> consumed, no output; then SOF with TxEn=0 -> stalled until TxEn=1, then the preamble appears.
REQ-041 Reset_n pulsed low during word 5 -> all outputs 0 in the same cycle, counters 0; after release, a new SOF gives the preamble without an IFG wait.
